scene_ctrl: RTL and testbench
=============================

SCENE_CTRL -- requirements
Module: scene_ctrl

Interface
REQ-001 Parameter HOLD_FRAMES, default 180: frames a WIN/LOSE scene is held before returning to TITLE.
REQ-002 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 start_btn  in  1  debounced one-cycle pulse: start/skip request.
REQ-005 player_win, player_lose  in  1 each  one-cycle game-result pulses.
REQ-006 h_cnt, v_cnt  in  10 each  VGA pixel counters (may hold a value for several clk cycles).
REQ-007 valid  in  1  VGA visible-area enable.
REQ-008 title_addr, win_addr, lose_addr, game_addr  in  17 each  scene pixel addresses.
REQ-009 game_data  in  12  game-renderer pixel colour.
REQ-010 mem_data  in  12  shared image BRAM read data; 1-cycle read latency.
REQ-011 mem_addr  out  17  shared image BRAM address.
REQ-012 vga_data  out  12  final pixel colour.
REQ-013 scene  out  2  current scene: 0 TITLE, 1 GAME, 2 WIN, 3 LOSE.
REQ-014 game_en  out  1  high only while scene==GAME.

Function
REQ-015 frame_tick SHALL pulse for exactly one clk cycle on the first cycle where (h_cnt,v_cnt)==(0,0) after any cycle where it was not.
REQ-016 The FSM SHALL have states TITLE, GAME, WIN, LOSE; scene SHALL change only on a frame_tick cycle.
REQ-017 start_btn in TITLE, or in WIN/LOSE, SHALL set a pending-start flag; start_btn in GAME SHALL be ignored.
REQ-018 player_win/player_lose in GAME SHALL set a pending result; both in one cycle records LOSE (lose priority); pulses outside GAME SHALL be ignored.
REQ-019 Once a result is pending, later result pulses SHALL not overwrite it.
REQ-020 On frame_tick: TITLE with pending start -> GAME; GAME with pending result -> WIN or LOSE; WIN/LOSE with pending start, or hold counter == HOLD_FRAMES-1 -> TITLE; pending flags clear on the taken transition.
REQ-021 A pending event arriving in the same cycle as frame_tick SHALL be taken on that tick.
REQ-022 Hold counter SHALL reset to 0 on entering WIN/LOSE, increment on each frame_tick in WIN/LOSE, and saturate (never wrap).
REQ-023 mem_addr SHALL be combinational: title_addr in TITLE, game_addr in GAME, win_addr in WIN, lose_addr in LOSE.
REQ-024 scene and valid SHALL be registered one cycle (scene_d, valid_d) to align with BRAM latency.
REQ-025 vga_data SHALL be combinational: 12'h000 when valid_d==0; else game_data when scene_d==GAME; else mem_data.
REQ-026 game_en SHALL equal (scene==GAME), combinationally.

Reset
REQ-027 rst SHALL force scene=TITLE, clear pending flags, hold counter=0, scene_d=TITLE, valid_d=0, and the frame-edge history register=1 (no frame_tick in the cycle after reset release while counters sit at (0,0)).
REQ-028 rst asserted mid-GAME or mid-WIN/LOSE SHALL return to TITLE on the next edge regardless of frame_tick or pending events; post-reset outputs: vga_data=12'h000, game_en=0, mem_addr=title_addr.

Verification
REQ-029 Reset, then start_btn mid-frame -> scene stays 0 until next (0,0), then scene=1, game_en=1 the same cycle.
REQ-030 In GAME, player_win and player_lose in same cycle -> next frame_tick scene=3; a later win pulse before tick does not change it.
REQ-031 In WIN with HOLD_FRAMES=3, no input -> scene=0 exactly on the 3rd frame_tick after entry.
REQ-032 In LOSE, start_btn at frame 1 -> scene=0 at next frame_tick; hold counter ignored.
REQ-033 valid=1, scene TITLE, mem_data=12'hf09 -> vga_data=12'hf09 one cycle after valid rises; valid=0 -> 12'h000 one cycle later.
REQ-034 h_cnt/v_cnt held at (0,0) for 4 clk cycles -> exactly one frame_tick; rst during GAME -> scene=0, game_en=0 next cycle.

Source files
------------

// File: rtl/scene_ctrl.sv
// Scene sequencer for a VGA game: TITLE -> GAME -> WIN/LOSE -> TITLE.
// Owns the shared image BRAM address mux and the final pixel colour select.
module scene_ctrl #(
  parameter int HOLD_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        player_win,
  input  logic        player_lose,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic [16:0] title_addr,
  input  logic [16:0] win_addr,
  input  logic [16:0] lose_addr,
  input  logic [16:0] game_addr,
  input  logic [11:0] game_data,
  input  logic [11:0] mem_data,
  output logic [16:0] mem_addr,
  output logic [11:0] vga_data,
  output logic [1:0]  scene,
  output logic        game_en
);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    GAME  = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } state_t;

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  state_t        state, state_n;
  state_t        scene_d;
  logic          valid_d;
  logic          prev_origin;
  logic          start_pend, start_n;
  logic          res_pend, res_n;
  logic          res_lose, lose_n;
  logic [HW-1:0] hold, hold_n;

  logic at_origin;
  logic frame_tick;
  logic in_game;
  logic start_now;
  logic res_now;
  logic lose_now;

  assign at_origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign frame_tick = at_origin & ~prev_origin;
  assign in_game    = (state == GAME);

  // Same-cycle events are folded in so a pulse coinciding with the tick counts.
  assign start_now = start_pend | (start_btn & ~in_game);
  assign res_now   = res_pend | (in_game & (player_win | player_lose));
  assign lose_now  = res_pend ? res_lose : player_lose;

  always_comb begin
    state_n = state;
    start_n = start_now;
    res_n   = res_now;
    lose_n  = res_now & lose_now;
    hold_n  = hold;
    unique case (state)
      TITLE: begin
        if (frame_tick && start_now) begin
          state_n = GAME;
          start_n = 1'b0;
          res_n   = 1'b0;
          lose_n  = 1'b0;
        end
      end
      GAME: begin
        if (frame_tick && res_now) begin
          state_n = lose_now ? LOSE : WIN;
          hold_n  = '0;
          start_n = 1'b0;
          res_n   = 1'b0;
          lose_n  = 1'b0;
        end
      end
      WIN, LOSE: begin
        if (frame_tick) begin
          if (start_now || hold == HOLD_LAST) begin
            state_n = TITLE;
            hold_n  = '0;
            start_n = 1'b0;
            res_n   = 1'b0;
            lose_n  = 1'b0;
          end else if (hold != HOLD_MAX) begin
            hold_n = hold + 1'b1;
          end
        end
      end
      default: state_n = TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TITLE;
      start_pend  <= 1'b0;
      res_pend    <= 1'b0;
      res_lose    <= 1'b0;
      hold        <= '0;
      scene_d     <= TITLE;
      valid_d     <= 1'b0;
      prev_origin <= 1'b1;
    end else begin
      state       <= state_n;
      start_pend  <= start_n;
      res_pend    <= res_n;
      res_lose    <= lose_n;
      hold        <= hold_n;
      scene_d     <= state;
      valid_d     <= valid;
      prev_origin <= at_origin;
    end
  end

  always_comb begin
    mem_addr = title_addr;
    unique case (state)
      TITLE:   mem_addr = title_addr;
      GAME:    mem_addr = game_addr;
      WIN:     mem_addr = win_addr;
      LOSE:    mem_addr = lose_addr;
      default: mem_addr = title_addr;
    endcase
  end

  // scene_d/valid_d line up with the one-cycle BRAM read.
  always_comb begin
    vga_data = 12'h000;
    if (valid_d) begin
      vga_data = (scene_d == GAME) ? game_data : mem_data;
    end
  end

  assign scene   = state;
  assign game_en = (state == GAME);

endmodule

// File: tb/tb_scene_ctrl.sv
// Directed bench for scene_ctrl with a short hold time.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_scene_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, player_win, player_lose;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid;
  logic [16:0] title_addr, win_addr, lose_addr, game_addr;
  logic [11:0] game_data, mem_data;
  logic [16:0] mem_addr;
  logic [11:0] vga_data;
  logic [1:0]  scene;
  logic        game_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scene_ctrl #(.HOLD_FRAMES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .player_win  (player_win),
    .player_lose (player_lose),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .title_addr  (title_addr),
    .win_addr    (win_addr),
    .lose_addr   (lose_addr),
    .game_addr   (game_addr),
    .game_data   (game_data),
    .mem_data    (mem_data),
    .mem_addr    (mem_addr),
    .vga_data    (vga_data),
    .scene       (scene),
    .game_en     (game_en)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] obs,
                     input logic [16:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame boundary: leave origin for a cycle, then land on (0,0).
  task automatic do_frame();
    h_cnt = 10'd100; v_cnt = 10'd1;
    step();
    h_cnt = 10'd0; v_cnt = 10'd0;
    step();
  endtask

  task automatic pulse_start();
    h_cnt = 10'd10; v_cnt = 10'd3;
    step();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_btn = 0; player_win = 0; player_lose = 0;
    h_cnt = 0; v_cnt = 0; valid = 0;
    title_addr = 17'h01111; game_addr = 17'h02222;
    win_addr   = 17'h03333; lose_addr = 17'h04444;
    game_data  = 12'h0a5;   mem_data  = 12'hf09;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("reset_scene", 17'(scene), 17'd0);
    chk("reset_game_en", 17'(game_en), 17'd0);
    chk("reset_vga", 17'(vga_data), 17'h000);
    chk("reset_mem_addr", mem_addr, 17'h01111);

    pulse_start();
    step(); step();
    chk("start_waits_frame", 17'(scene), 17'd0);
    h_cnt = 0; v_cnt = 0;
    step();
    chk("start_to_game", 17'(scene), 17'd1);
    chk("game_en_on", 17'(game_en), 17'd1);
    chk("game_mem_addr", mem_addr, 17'h02222);

    step();
    player_win = 1'b1;
    step();
    player_win = 1'b0;
    step();
    chk("origin_hold_one_tick", 17'(scene), 17'd1);
    do_frame();
    chk("win_taken", 17'(scene), 17'd2);
    chk("win_mem_addr", mem_addr, 17'h03333);

    do_frame();
    chk("hold_tick1", 17'(scene), 17'd2);
    do_frame();
    chk("hold_tick2", 17'(scene), 17'd2);
    do_frame();
    chk("hold_tick3_title", 17'(scene), 17'd0);

    pulse_start();
    do_frame();
    chk("restart_game", 17'(scene), 17'd1);
    h_cnt = 10'd10; v_cnt = 10'd3;
    step();
    player_win = 1'b1; player_lose = 1'b1;
    step();
    player_win = 1'b0; player_lose = 1'b0;
    step();
    player_win = 1'b1;
    step();
    player_win = 1'b0;
    chk("result_still_game", 17'(scene), 17'd1);
    do_frame();
    chk("lose_priority", 17'(scene), 17'd3);
    chk("lose_mem_addr", mem_addr, 17'h04444);

    do_frame();
    chk("lose_frame1", 17'(scene), 17'd3);
    pulse_start();
    do_frame();
    chk("lose_skip_title", 17'(scene), 17'd0);

    h_cnt = 10'd10; v_cnt = 10'd3;
    step();
    h_cnt = 0; v_cnt = 0; start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("start_same_tick", 17'(scene), 17'd1);

    valid = 1'b1;
    step();
    chk("game_pixel", 17'(vga_data), 17'h0a5);
    valid = 1'b0;
    step();
    chk("game_blank", 17'(vga_data), 17'h000);

    valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 1'b0;
    chk("rst_mid_game_scene", 17'(scene), 17'd0);
    chk("rst_mid_game_en", 17'(game_en), 17'd0);
    chk("rst_mid_game_vga", 17'(vga_data), 17'h000);
    chk("rst_mid_game_addr", mem_addr, 17'h01111);

    h_cnt = 10'd10; v_cnt = 10'd3;
    valid = 1'b1;
    step();
    chk("title_pixel", 17'(vga_data), 17'hf09);
    valid = 1'b0;
    step();
    chk("title_blank", 17'(vga_data), 17'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
